// File: rtl/iir_biquad_cascade_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iir_pkg
// Description : Shared types, constants and the round/saturate helper for
//               the time-multiplexed biquad cascade.
// Revision    : 1.0 - initial release
// ============================================================================
package iir_pkg;

  typedef enum logic [1:0] {IDLE, MAC, WB, OUT} state_e;

  // Tap order matches the coefficient address layout within a section
  typedef enum logic [2:0] {B0, B1, B2, A1, A2} tap_e;

  localparam int TAPS_PER_SECTION = 5;

  // Round half up by COEF_FRAC bits, then clamp to a signed data_w range.
  // Works on a 64-bit container so any legal ACC_W fits.
  function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc,
                                                   input int frac,
                                                   input int data_w);
    logic signed [63:0] rounded;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    rounded = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
    max_v   = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    min_v   = -(64'sd1 <<< (data_w - 1));
    if (rounded > max_v) begin
      return max_v;
    end else if (rounded < min_v) begin
      return min_v;
    end
    return rounded;
  endfunction

endpackage
`default_nettype wire

// File: rtl/iir_biquad_cascade_mac_unit.sv
`default_nettype none
// ============================================================================
// Module      : iir_mac_unit
// Description : Single signed multiplier feeding an add/subtract accumulator.
//               Products are full precision and sign-extended to ACC_W.
// Revision    : 1.0 - initial release
// ============================================================================
module iir_mac_unit #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ACC_W  = DATA_W + COEF_W + 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clr,
  input  logic                     i_en,
  input  logic                     i_sub,
  input  logic signed [COEF_W-1:0] i_coef,
  input  logic signed [DATA_W-1:0] i_opnd,
  output logic signed [ACC_W-1:0]  o_acc
);

  localparam int c_prod_w = DATA_W + COEF_W;

  logic signed [c_prod_w-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_prod_ext;
  logic signed [ACC_W-1:0]    r_acc;

  assign w_prod     = i_coef * i_opnd;
  assign w_prod_ext = {{(ACC_W - c_prod_w){w_prod[c_prod_w-1]}}, w_prod};
  assign o_acc      = r_acc;

  // Accumulate one signed product per enabled cycle; clear starts a new sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= i_sub ? (r_acc - w_prod_ext) : (r_acc + w_prod_ext);
    end
  end

endmodule
`default_nettype wire

// File: rtl/iir_biquad_cascade.sv
`default_nettype none
// ============================================================================
// Module      : iir_biquad_cascade
// Description : NUM_SECTIONS direct-form-I biquads evaluated in turn by one
//               shared MAC, one tap per cycle, with runtime-loadable
//               coefficients and a valid/ready sample handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module iir_biquad_cascade
  import iir_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int COEF_W       = 16,
  parameter int COEF_FRAC    = 14,
  parameter int NUM_SECTIONS = 2,
  parameter int ACC_W        = DATA_W + COEF_W + 4
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            in_valid,
  output logic                                            in_ready,
  input  logic signed [DATA_W-1:0]                        x_in,
  output logic                                            out_valid,
  output logic signed [DATA_W-1:0]                        y_out,
  input  logic                                            coef_we,
  input  logic [$clog2(TAPS_PER_SECTION*NUM_SECTIONS)-1:0] coef_addr,
  input  logic signed [COEF_W-1:0]                        coef_wdata,
  output logic                                            busy
);

  localparam int c_ncoef  = TAPS_PER_SECTION * NUM_SECTIONS;
  localparam int c_addr_w = $clog2(c_ncoef);
  localparam int c_sec_w  = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1;
  localparam logic [c_sec_w-1:0]       c_last_sec = c_sec_w'(NUM_SECTIONS - 1);
  localparam logic signed [COEF_W-1:0] c_unity    = COEF_W'(1 << COEF_FRAC);

  state_e                    r_state;
  tap_e                      r_tap;
  logic [c_sec_w-1:0]        r_sec;
  logic signed [DATA_W-1:0]  r_sec_in;
  logic signed [DATA_W-1:0]  r_x1 [NUM_SECTIONS];
  logic signed [DATA_W-1:0]  r_x2 [NUM_SECTIONS];
  logic signed [DATA_W-1:0]  r_y1 [NUM_SECTIONS];
  logic signed [DATA_W-1:0]  r_y2 [NUM_SECTIONS];
  logic signed [COEF_W-1:0]  r_coef [c_ncoef];
  logic                      r_in_ready;
  logic                      r_out_valid;
  logic                      r_busy;
  logic signed [DATA_W-1:0]  r_y_out;

  logic                      w_accept;
  logic                      w_last;
  logic [c_addr_w-1:0]       w_cidx;
  logic signed [COEF_W-1:0]  w_coef;
  logic signed [DATA_W-1:0]  w_opnd;
  logic                      w_sub;
  logic                      w_mac_clr;
  logic                      w_mac_en;
  logic signed [ACC_W-1:0]   w_acc;
  logic signed [DATA_W-1:0]  w_y;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign y_out     = r_y_out;

  // in_ready is high exactly while the FSM sits in IDLE
  assign w_accept  = in_valid & r_in_ready;
  assign w_last    = (r_sec == c_last_sec);
  assign w_cidx    = c_addr_w'(r_sec) * c_addr_w'(TAPS_PER_SECTION) + c_addr_w'(r_tap);
  assign w_coef    = r_coef[w_cidx];
  assign w_mac_clr = ((r_state == IDLE) && w_accept) || ((r_state == WB) && !w_last);
  assign w_mac_en  = (r_state == MAC);
  assign w_y       = DATA_W'(sat_round(64'(w_acc), COEF_FRAC, DATA_W));

  // Select the data operand for the current tap; feedback taps subtract
  always_comb begin
    w_opnd = r_sec_in;
    w_sub  = 1'b0;
    case (r_tap)
      B1: w_opnd = r_x1[r_sec];
      B2: w_opnd = r_x2[r_sec];
      A1: begin
        w_opnd = r_y1[r_sec];
        w_sub  = 1'b1;
      end
      A2: begin
        w_opnd = r_y2[r_sec];
        w_sub  = 1'b1;
      end
      default: ;
    endcase
  end

  iir_mac_unit #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_mac_clr),
    .i_en   (w_mac_en),
    .i_sub  (w_sub),
    .i_coef (w_coef),
    .i_opnd (w_opnd),
    .o_acc  (w_acc)
  );

  // Coefficient bank: identity at reset, writable only in an idle, non-accepting cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_ncoef; i++) begin
        r_coef[i] <= ((i % TAPS_PER_SECTION) == 0) ? c_unity : '0;
      end
    end else if (coef_we && (r_state == IDLE) && !w_accept && (int'(coef_addr) < c_ncoef)) begin
      r_coef[coef_addr] <= coef_wdata;
    end
  end

  // Sequencer: accept, five MAC taps per section, write-back, then present the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_tap       <= B0;
      r_sec       <= '0;
      r_sec_in    <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_y_out     <= '0;
      for (int s = 0; s < NUM_SECTIONS; s++) begin
        r_x1[s] <= '0;
        r_x2[s] <= '0;
        r_y1[s] <= '0;
        r_y2[s] <= '0;
      end
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_sec_in   <= x_in;
            r_sec      <= '0;
            r_tap      <= B0;
            r_state    <= MAC;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        MAC: begin
          if (r_tap == A2) begin
            r_state <= WB;
          end else begin
            r_tap <= tap_e'(r_tap + 3'd1);
          end
        end
        WB: begin
          r_x2[r_sec] <= r_x1[r_sec];
          r_x1[r_sec] <= r_sec_in;
          r_y2[r_sec] <= r_y1[r_sec];
          r_y1[r_sec] <= w_y;
          // The saturated output becomes the next section's input
          r_sec_in    <= w_y;
          if (w_last) begin
            r_state <= OUT;
          end else begin
            r_sec   <= r_sec + c_sec_w'(1);
            r_tap   <= B0;
            r_state <= MAC;
          end
        end
        OUT: begin
          r_y_out     <= r_sec_in;
          r_out_valid <= 1'b1;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iir_biquad_cascade.sv
`default_nettype none
// ============================================================================
// Module      : tb_iir_biquad_cascade
// Description : Scoreboard bench for the biquad cascade. A reference model
//               computes each expected sample when it is accepted; results
//               are popped and compared when out_valid pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iir_biquad_cascade;

  localparam int DATA_W       = 16;
  localparam int COEF_W       = 16;
  localparam int COEF_FRAC    = 14;
  localparam int NUM_SECTIONS = 2;
  localparam int NCOEF        = 5 * NUM_SECTIONS;
  localparam int ADDR_W       = 4;
  localparam longint LATENCY  = 13;
  localparam longint PERIOD   = 14;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] x_in;
  logic                     out_valid;
  logic signed [DATA_W-1:0] y_out;
  logic                     coef_we;
  logic [ADDR_W-1:0]        coef_addr;
  logic signed [COEF_W-1:0] coef_wdata;
  logic                     busy;

  always #5 clk = ~clk;

  iir_biquad_cascade #(
    .DATA_W       (DATA_W),
    .COEF_W       (COEF_W),
    .COEF_FRAC    (COEF_FRAC),
    .NUM_SECTIONS (NUM_SECTIONS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .x_in       (x_in),
    .out_valid  (out_valid),
    .y_out      (y_out),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .busy       (busy)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input longint act, input longint exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  longint m_c  [NCOEF];
  longint m_x1 [NUM_SECTIONS];
  longint m_x2 [NUM_SECTIONS];
  longint m_y1 [NUM_SECTIONS];
  longint m_y2 [NUM_SECTIONS];

  task automatic mdl_reset();
    for (int i = 0; i < NCOEF; i++) m_c[i] = ((i % 5) == 0) ? 64'sd16384 : 64'sd0;
    for (int s = 0; s < NUM_SECTIONS; s++) begin
      m_x1[s] = 0; m_x2[s] = 0; m_y1[s] = 0; m_y2[s] = 0;
    end
  endtask

  function automatic longint sat_rnd(input longint acc);
    longint r;
    r = (acc + 64'sd8192) >>> 14;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  task automatic mdl_step(input longint x, output longint y);
    longint xin, acc, ys;
    xin = x;
    for (int s = 0; s < NUM_SECTIONS; s++) begin
      acc = m_c[5*s] * xin + m_c[5*s+1] * m_x1[s] + m_c[5*s+2] * m_x2[s]
          - m_c[5*s+3] * m_y1[s] - m_c[5*s+4] * m_y2[s];
      ys = sat_rnd(acc);
      m_x2[s] = m_x1[s]; m_x1[s] = xin;
      m_y2[s] = m_y1[s]; m_y1[s] = ys;
      xin = ys;
    end
    y = xin;
  endtask

  // ---------------- scoreboard ----------------
  longint q_exp [$];
  longint q_cyc [$];
  longint cyc       = 0;
  longint last_y    = 0;
  int     n_ov      = 0;
  int     n_acc     = 0;
  bit     cont_mode = 1'b0;
  longint cont_prev = -1;

  always @(posedge clk) cyc <= cyc + 1;

  // Compare completed outputs, then record any accept happening at the next edge
  always @(negedge clk) begin
    longint e, a;
    if (out_valid) begin
      n_ov++;
      last_y = y_out;
      if (q_exp.size() == 0) begin
        check("spurious_out_valid", 1, 0);
      end else begin
        e = q_exp.pop_front();
        a = q_cyc.pop_front();
        check("y_out", y_out, e);
        check("latency", cyc - a, LATENCY);
      end
    end
    if (rst_n && in_valid && in_ready) begin
      mdl_step(longint'(x_in), e);
      q_exp.push_back(e);
      q_cyc.push_back(cyc + 1);
      n_acc++;
      if (cont_mode) begin
        if (cont_prev >= 0) check("accept_gap", cyc + 1 - cont_prev, PERIOD);
        cont_prev = cyc + 1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input longint x);
    int k = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    x_in     = 16'(x);
    @(negedge clk);
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (q_exp.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (q_exp.size() != 0) begin
      check("drain_timeout", longint'(q_exp.size()), 0);
      q_exp.delete();
      q_cyc.delete();
    end
    #1;
  endtask

  task automatic wcoef(input int addr, input longint val, input bit take);
    @(posedge clk); #1;
    coef_we    = 1'b1;
    coef_addr  = 4'(addr);
    coef_wdata = 16'(val);
    @(posedge clk); #1;
    coef_we    = 1'b0;
    if (take) m_c[addr] = val;
  endtask

  // Hard stop in case anything hangs
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rec_exp [4];
    int acc_before;
    int ov_before;
    rec_exp = '{8192, 4096, 2048, 1024};

    rst_n = 1'b0; in_valid = 1'b0; x_in = '0;
    coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
    mdl_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_y_out", y_out, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Identity coefficients after reset
    send(1000);   drain(); check("ident_1000", last_y, 1000);
    send(-32768); drain(); check("ident_min", last_y, -32768);

    // Half gain with round half up
    wcoef(0, 8192, 1'b1);
    send(16384); drain(); check("gain_half", last_y, 8192);
    send(3);     drain(); check("gain_round", last_y, 2);

    // Single pole at 0.5, starting from flushed history
    wcoef(0, 16384, 1'b1);
    send(0); send(0); drain();
    wcoef(3, -8192, 1'b1);
    send(16384); drain(); check("rec_0", last_y, 16384);
    for (int i = 0; i < 4; i++) begin
      send(0); drain(); check("rec_tail", last_y, rec_exp[i]);
    end

    // Saturation through both sections
    wcoef(3, 0, 1'b1);
    wcoef(0, 32767, 1'b1);
    wcoef(5, 32767, 1'b1);
    send(30000);  drain(); check("sat_pos", last_y, 32767);
    send(-30000); drain(); check("sat_neg", last_y, -32768);

    // Continuous in_valid: one accept every PERIOD cycles
    wcoef(0, 16384, 1'b1);
    wcoef(5, 16384, 1'b1);
    acc_before = n_acc;
    cont_prev  = -1;
    cont_mode  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1;
    x_in     = 16'sd1234;
    repeat (70) @(posedge clk);
    #1;
    in_valid  = 1'b0;
    cont_mode = 1'b0;
    drain();
    check("accept_count", n_acc - acc_before, 5);
    check("cont_value", last_y, 1234);

    // Coefficient write while busy must be dropped
    send(700);
    @(negedge clk);
    check("busy_high", busy, 1);
    check("ready_low", in_ready, 0);
    wcoef(0, 8192, 1'b0);
    drain(); check("busy_wr_a", last_y, 700);
    send(700); drain(); check("busy_wr_b", last_y, 700);

    // Random coefficients exercise every tap and the feedback path
    for (int i = 0; i < NCOEF; i++) begin
      wcoef(i, longint'($urandom_range(0, 24000)) - 12000, 1'b1);
    end
    for (int i = 0; i < 8; i++) begin
      send(longint'($urandom_range(0, 40000)) - 20000);
    end
    drain();

    // Asynchronous reset in the middle of a computation
    send(1111);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    q_exp.delete();
    q_cyc.delete();
    mdl_reset();
    ov_before = n_ov;
    @(negedge clk);
    check("arst_y_out", y_out, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("arst_no_output", n_ov - ov_before, 0);
    send(500); drain(); check("arst_identity", last_y, 500);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/iir_biquad_cascade.md
Name: iir_biquad_cascade

Overview:
- Parametrised cascade of NUM_SECTIONS direct-form-I biquad sections for the audio filter chain. Generalises the single fixed-coefficient biquad.
- A single time-multiplexed multiplier-accumulator evaluates all sections in turn, one tap per cycle.
- Coefficients are runtime-loadable through a register port. Q2.14 coefficients cover the |a1| ≥ 1 range.
- Outputs are rounded and saturated. A valid/ready handshake replaces the bare new_data strobe.

Parameters:
- DATA_W, 16, sample width, signed Q1.(DATA_W-1)
- COEF_W, 16, coefficient width, signed
- COEF_FRAC, 14, coefficient fractional bits (Q2.14 at default)
- NUM_SECTIONS, 2, number of cascaded biquads, 1..8
- ACC_W, DATA_W+COEF_W+4, accumulator width (derived; do not override)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample (high only in IDLE)
- x_in  in  DATA_W  input sample, signed
- out_valid  out  1  one-cycle pulse, y_out valid
- y_out  out  DATA_W  filtered sample, signed; held until next result
- coef_we  in  1  coefficient write strobe
- coef_addr  in  $clog2(5*NUM_SECTIONS)  coefficient index = section*5 + tap; tap order b0,b1,b2,a1,a2
- coef_wdata  in  COEF_W  coefficient value
- busy  out  1  computation in progress

Behaviour:
- Reset (asynchronous, rst_n low):
  - FSM to IDLE; in_ready=1, out_valid=0, y_out=0, busy=0.
  - All x1/x2/y1/y2 state registers cleared.
  - Coefficients set to identity: b0=1<<COEF_FRAC, all other taps 0.
  - Reset mid-computation aborts the sample; no out_valid is produced for it.
- Section k computes: acc = b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2.
  - Products are full-precision, sign-extended to ACC_W.
  - y = sat(round(acc)), where round = add 2^(COEF_FRAC-1), then arithmetic shift right by COEF_FRAC.
  - sat clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Section 0 input is the accepted x_in. Section k+1 input is the saturated y of section k.
- FSM:
  - IDLE: on in_valid && in_ready, latch x_in, section=0, tap=0, clear acc, go to MAC.
  - MAC: one tap per cycle, tap 0..4, acc += ±coef*operand. After tap 4, go to WB.
  - WB (1 cycle):
    - Round and saturate the result.
    - Shift the section state: x2<=x1, x1<=section input, y2<=y1, y1<=y.
    - If last section, go to OUT. Otherwise section++, tap=0, clear acc, go to MAC.
  - OUT (1 cycle): y_out<=final y, out_valid=1, go to IDLE.
- Latency: out_valid is asserted exactly 6*NUM_SECTIONS+1 cycles after the accepting edge (13 at default). Throughput is one sample per 6*NUM_SECTIONS+2 cycles.
- in_valid while not IDLE: ignored, not queued. The upstream source must hold in_valid until in_ready.
- Coefficient writes:
  - Take effect only when the FSM is in IDLE and no accept occurs in the same cycle. Writes in any other cycle are dropped silently.
  - An addr ≥ 5*NUM_SECTIONS is ignored.
- Accept and coef_we in the same IDLE cycle: the sample is accepted; the write is dropped.
- The accumulator must not wrap for any coefficient/data values; ACC_W provides headroom for 5 worst-case products.

Decomposition:
- Package iir_pkg:
  - state enum {IDLE, MAC, WB, OUT}
  - tap enum {B0, B1, B2, A1, A2}
  - TAPS_PER_SECTION=5
  - sat_round function (acc, COEF_FRAC, DATA_W)
- Sub-module iir_mac_unit: one signed multiplier plus accumulator with clear/add/subtract control. It is the only multiplier in the block.

Test Plan:
- Reset identity, defaults: x_in=1000 accepted → out_valid 13 cycles later, y_out=1000; x_in=-32768 → y_out=-32768.
- Gain: load section0 b0=8192 (0.5) → x_in=16384 gives y_out=8192; x_in=3 gives y_out=2 (round half up from 1.5).
- Recursion: section0 b0=16384, a1=-8192 (pole at 0.5); impulse 16384 then zeros → y_out sequence 16384, 8192, 4096, 2048, 1024.
- Saturation: both sections b0=32767 (≈2.0) → x_in=30000 gives y_out=32767; x_in=-30000 gives y_out=-32768; no wrap.
- Handshake: in_valid held high continuously → exactly one accept per 14 cycles; coef_we during busy leaves the coefficient unchanged (verify with next sample).
- Async reset: assert rst_n low at cycle 5 of a computation → out_valid never pulses for that sample; y_out=0; next sample x_in=500 → y_out=500 (identity coefficients restored).
